dct_row_arbiter: RTL and testbench

- Shares one pipelined 8-point row DCT between NUM_REQ independent row streams.
- Arbitration is round-robin at block granularity. A grant holds until the requester's last row of the block.
- Each issued row is tagged with its requester ID and last flag. DCT results are buffered and returned on a single tagged output stream with valid/ready.
- Credit-based issue guarantees the non-stallable DCT pipeline never overruns the output buffer.

---
 rtl/dct_arb_pkg.sv | 20 ++
 rtl/dct_arb_fifo.sv | 61 ++++++
 rtl/dct_row_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_dct_row_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_arb_pkg.sv
// Shared types and helpers for the DCT row arbiter: state encoding, row type,
// and ID-width helper.
package dct_arb_pkg;

  localparam int COEF_WIDTH_DEF = 16;
  localparam int ROW_W          = 8 * COEF_WIDTH_DEF;

  typedef logic [ROW_W-1:0] row_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Width needed to carry a requester index; never below one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dct_arb_fifo.sv
// Synchronous FIFO with registered write and combinational head read.
// The count output lets the caller compare occupancies of sibling FIFOs.
module dct_arb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // alone define which entries are valid, and a reset-free array maps to RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/dct_row_arbiter.sv
// Block-granular round-robin arbiter sharing one pipelined row DCT, with
// credit-limited issue and a tagged in-order return stream.
// Optional counters are enabled by defining DCT_ROW_ARBITER_PERF_EN.
module dct_row_arbiter
  import dct_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int COEF_WIDTH = COEF_WIDTH_DEF,
  parameter int DEPTH      = 16
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*8*COEF_WIDTH-1:0] req_row,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic                            dct_en,
  output logic [8*COEF_WIDTH-1:0]         dct_row,
  input  logic                            dct_out_en,
  input  logic [8*COEF_WIDTH-1:0]         dct_row_out,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [8*COEF_WIDTH-1:0]         out_row,
  output logic [$clog2(NUM_REQ)-1:0]      out_id,
  output logic                            out_last,
`ifdef DCT_ROW_ARBITER_PERF_EN
  output logic [31:0]                     perf_rows,
  output logic [31:0]                     perf_stall,
  output logic [NUM_REQ*16-1:0]           perf_blocks,
`endif
  output logic                            err
);

  localparam int RW = 8 * COEF_WIDTH;
  localparam int IW = id_width(NUM_REQ);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = IW + 1;

  state_e        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] credits_q, credits_d;
  logic          err_q, err_d;

  logic          scan_found;
  logic [IW-1:0] scan_g;
  logic          act_valid;
  logic [IW-1:0] act_g;
  logic          has_credit;
  logic          issue;
  logic          pop;
  logic          spurious;

  logic          tag_push, tag_full, tag_empty;
  logic [TW-1:0] tag_head;
  logic [CW-1:0] tag_count;
  logic          data_push, data_full, data_empty;
  logic [RW-1:0] data_head;
  logic [CW-1:0] data_count;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == IW'(NUM_REQ - 1)) ? '0 : idx + IW'(1);
  endfunction

  // First valid requester at or after the pointer, scanning upward with wrap.
  always_comb begin : scan_p
    logic [IW-1:0] cand;
    scan_found = 1'b0;
    scan_g     = '0;
    cand       = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!scan_found && req_valid[cand]) begin
        scan_found = 1'b1;
        scan_g     = cand;
      end
      cand = next_idx(cand);
    end
  end

  assign has_credit = (credits_q != '0);

  // NOTE: every combinational output gets a default before any branch so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    act_valid = 1'b0;
    act_g     = grant_q;
    if (state_q == BUSY) begin
      act_valid = 1'b1;
    end else if (scan_found && has_credit) begin
      act_valid = 1'b1;
      act_g     = scan_g;
    end
  end

  always_comb begin
    req_ready = '0;
    if (act_valid && has_credit) begin
      req_ready[act_g] = 1'b1;
    end
  end

  assign issue   = act_valid && has_credit && req_valid[act_g];
  assign dct_en  = issue;
  assign dct_row = issue ? req_row[act_g*RW +: RW] : '0;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (issue && req_last[act_g]) begin
      state_d = IDLE;
      ptr_d   = next_idx(act_g);
    end else if (act_valid) begin
      state_d = BUSY;
      grant_d = act_g;
    end
  end

  assign pop = out_valid && out_ready;

  always_comb begin
    credits_d = credits_q;
    case ({issue, pop})
      2'b10:   credits_d = credits_q - CW'(1);
      2'b01:   credits_d = credits_q + CW'(1);
      default: credits_d = credits_q;
    endcase
  end

  // Equal occupancies mean no issued row is awaiting its result.
  assign spurious  = (tag_count == data_count);
  assign err_d     = err_q || (dct_out_en && spurious);
  assign tag_push  = issue && !tag_full;
  assign data_push = dct_out_en && !spurious && !data_full;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      credits_q <= CW'(DEPTH);
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  dct_arb_fifo #(
    .WIDTH (TW),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk     (aclk),
    .rst     (areset),
    .push_i  (tag_push),
    .din_i   ({act_g, req_last[act_g]}),
    .pop_i   (pop),
    .dout_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (tag_count)
  );

  dct_arb_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_data_fifo (
    .clk     (aclk),
    .rst     (areset),
    .push_i  (data_push),
    .din_i   (dct_row_out),
    .pop_i   (pop),
    .dout_o  (data_head),
    .full_o  (data_full),
    .empty_o (data_empty),
    .count_o (data_count)
  );

  // Heads are gated so the outputs read zero while nothing is buffered.
  assign out_valid = !data_empty && !tag_empty;
  assign out_row   = out_valid ? data_head : '0;
  assign out_id    = out_valid ? tag_head[TW-1:1] : '0;
  assign out_last  = out_valid && tag_head[0];
  assign err       = err_q;

`ifdef DCT_ROW_ARBITER_PERF_EN
  logic [31:0]         perf_rows_q;
  logic [31:0]         perf_stall_q;
  logic [NUM_REQ*16-1:0] perf_blocks_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      perf_rows_q   <= '0;
      perf_stall_q  <= '0;
      perf_blocks_q <= '0;
    end else begin
      if (issue) begin
        perf_rows_q <= perf_rows_q + 32'd1;
      end
      if (state_q == BUSY && req_valid[grant_q] && !has_credit) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (issue && req_last[act_g]) begin
        perf_blocks_q[act_g*16 +: 16] <= perf_blocks_q[act_g*16 +: 16] + 16'd1;
      end
    end
  end

  assign perf_rows   = perf_rows_q;
  assign perf_stall  = perf_stall_q;
  assign perf_blocks = perf_blocks_q;
`endif

endmodule

// File: tb/tb_dct_row_arbiter.sv
// Directed bench for dct_row_arbiter: requester models, a variable-latency
// DCT delay line, and hand-computed expectations for each scenario.
`timescale 1ns/1ps
module tb_dct_row_arbiter;

  localparam int NR   = 4;
  localparam int CWID = 16;
  localparam int DEP  = 4;
  localparam int RW   = 8 * CWID;
  localparam int IDW  = 2;

  logic              aclk = 1'b0;
  logic              areset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*RW-1:0]  req_row;
  logic [NR-1:0]     req_last;
  logic              dct_en;
  logic [RW-1:0]     dct_row;
  logic              dct_out_en;
  logic [RW-1:0]     dct_row_out;
  logic              out_valid;
  logic              out_ready;
  logic [RW-1:0]     out_row;
  logic [IDW-1:0]    out_id;
  logic              out_last;
  logic              err;
`ifdef DCT_ROW_ARBITER_PERF_EN
  logic [31:0]       perf_rows;
  logic [31:0]       perf_stall;
  logic [NR*16-1:0]  perf_blocks;
`endif

  always #5 aclk = ~aclk;

  dct_row_arbiter #(
    .NUM_REQ    (NR),
    .COEF_WIDTH (CWID),
    .DEPTH      (DEP)
  ) dut (
    .aclk        (aclk),
    .areset      (areset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_row     (req_row),
    .req_last    (req_last),
    .dct_en      (dct_en),
    .dct_row     (dct_row),
    .dct_out_en  (dct_out_en),
    .dct_row_out (dct_row_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .out_id      (out_id),
    .out_last    (out_last),
`ifdef DCT_ROW_ARBITER_PERF_EN
    .perf_rows   (perf_rows),
    .perf_stall  (perf_stall),
    .perf_blocks (perf_blocks),
`endif
    .err         (err)
  );

  // DCT stand-in: identity transform with selectable latency, reset with the DUT.
  int            lat = 5;
  logic [7:0]    p_v;
  logic [RW-1:0] p_d [8];
  logic          inj_en  = 1'b0;
  logic [RW-1:0] inj_row = '0;

  always @(posedge aclk) begin
    if (areset) p_v <= '0;
    else        p_v <= {p_v[6:0], dct_en};
    p_d[0] <= dct_row;
    for (int i = 1; i < 8; i++) p_d[i] <= p_d[i-1];
  end

  assign dct_out_en  = p_v[lat-1] | inj_en;
  assign dct_row_out = inj_en ? inj_row : p_d[lat-1];

  typedef struct {
    logic [IDW-1:0] id;
    logic           last;
    logic [RW-1:0]  row;
  } rec_t;

  rec_t issue_q[$];
  rec_t out_q[$];

  int   nblk [NR];
  int   len  [NR];
  int   idx  [NR];
  int   blk  [NR];
  bit   en   [NR];
  logic last_hs;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] make_row(input int r, input int b, input int i);
    logic [RW-1:0] v;
    for (int k = 0; k < 8; k++) v[k*CWID +: CWID] = 16'(r*4096 + b*256 + i*8 + k);
    return v;
  endfunction

  task automatic clear_reqs();
    for (int r = 0; r < NR; r++) begin
      nblk[r] = 0; len[r] = 1; idx[r] = 0; blk[r] = 0; en[r] = 1'b0;
    end
  endtask

  task automatic start(input int r, input int l, input int nb);
    len[r] = l; nblk[r] = nb; idx[r] = 0; en[r] = 1'b1;
  endtask

  // One clock: drive requesters, check the issue path, log both handshakes.
  task automatic tick();
    logic [NR-1:0] hs;
    int            g;
    rec_t          rec;
    for (int r = 0; r < NR; r++) begin
      req_valid[r]          = en[r] && (nblk[r] > 0);
      req_last[r]           = (idx[r] == len[r] - 1);
      req_row[r*RW +: RW]   = make_row(r, blk[r], idx[r]);
    end
    #1;
    hs      = req_valid & req_ready;
    last_hs = |hs;
    check("dct_en", RW'(dct_en), RW'(|hs));
    check("ready_onehot", RW'($countones(req_ready) > 1), '0);
    if (|hs) begin
      g = 0;
      for (int r = 0; r < NR; r++) if (hs[r]) g = r;
      check("dct_row", dct_row, req_row[g*RW +: RW]);
      rec.id   = IDW'(g);
      rec.last = req_last[g];
      rec.row  = req_row[g*RW +: RW];
      issue_q.push_back(rec);
      if (req_last[g]) begin
        idx[g] = 0; blk[g]++; nblk[g]--;
      end else begin
        idx[g]++;
      end
    end
    if (out_valid && out_ready) begin
      rec.id   = out_id;
      rec.last = out_last;
      rec.row  = out_row;
      out_q.push_back(rec);
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    clear_reqs();
    inj_en = 1'b0;
    tick();
    tick();
    areset = 1'b0;
    issue_q.delete();
    out_q.delete();
  endtask

  task automatic run_until(input string tag, input int n, input int budget);
    int k = 0;
    while (out_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, RW'(out_q.size()), RW'(n));
  endtask

  task automatic issue_until(input int n, input int budget);
    int k = 0;
    while (issue_q.size() < n && k < budget) begin
      tick();
      k++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_id [8] = '{1, 1, 3, 3, 1, 1, 3, 3};
    areset    = 1'b1;
    out_ready = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_row   = '0;
    clear_reqs();
    @(posedge aclk);
    #1;
    do_reset();

    check("rst_out_valid", RW'(out_valid), '0);
    check("rst_req_ready", RW'(req_ready), '0);
    check("rst_dct_en",    RW'(dct_en), '0);
    check("rst_err",       RW'(err), '0);
    check("rst_out_row",   out_row, '0);
    check("rst_out_id",    RW'(out_id), '0);
    check("rst_out_last",  RW'(out_last), '0);

    // Single requester, one 8-row block, latency 5, always-ready sink.
    lat = 5; out_ready = 1'b1;
    start(0, 8, 1);
    run_until("t1_outputs", 8, 300);
    check("t1_issued", RW'(issue_q.size()), RW'(8));
    for (int i = 0; i < 8; i++) begin
      if (i < out_q.size()) begin
        check("t1_id",   RW'(out_q[i].id), '0);
        check("t1_last", RW'(out_q[i].last), RW'(i == 7));
        check("t1_row",  out_q[i].row, make_row(0, 0, i));
      end
    end

    // Blocked sink: credits are back to DEPTH, so exactly DEPTH rows issue.
    out_ready = 1'b0;
    start(0, 8, 1);
    repeat (20) tick();
    check("t3_issued_stalled", RW'(issue_q.size()), RW'(8 + DEP));
    check("t3_ready_low",      RW'(req_ready), '0);
    check("t3_out_valid",      RW'(out_valid), RW'(1));
    out_ready = 1'b1;
    run_until("t3_outputs", 16, 300);
    check("t3_issued_all", RW'(issue_q.size()), RW'(16));
    for (int i = 0; i < 8; i++) begin
      if (8 + i < out_q.size()) begin
        check("t3_row",  out_q[8+i].row, make_row(0, 1, i));
        check("t3_last", RW'(out_q[8+i].last), RW'(i == 7));
      end
    end
    check("t3_err", RW'(err), '0);

    // Requesters 1 and 3, two 2-row blocks each, pointer 0.
    do_reset();
    lat = 5; out_ready = 1'b1;
    start(1, 2, 2);
    start(3, 2, 2);
    run_until("t2_outputs", 8, 300);
    for (int i = 0; i < 8; i++) begin
      if (i < issue_q.size()) check("t2_grant_id", RW'(issue_q[i].id), RW'(exp_id[i]));
      if (i < out_q.size()) begin
        check("t2_out_id",   RW'(out_q[i].id), RW'(exp_id[i]));
        check("t2_out_last", RW'(out_q[i].last), RW'(i % 2));
        check("t2_out_row",  out_q[i].row, make_row(exp_id[i], i / 4, i % 2));
      end
    end

    // Simultaneous issue and pop with one credit left, latency 1.
    do_reset();
    lat = 1; out_ready = 1'b0;
    start(0, 40, 1);
    issue_until(3, 50);
    en[0] = 1'b0;
    check("t4_fill", RW'(issue_q.size()), RW'(3));
    repeat (4) tick();
    check("t4_buffered", RW'(out_valid), RW'(1));
    en[0] = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t4_stream_issue", RW'(last_hs), RW'(1));
    end
    run_until("t4_outputs", 40, 300);
    if (out_q.size() == 40) begin
      check("t4_last_row",  out_q[39].row, make_row(0, 0, 39));
      check("t4_last_flag", RW'(out_q[39].last), RW'(1));
      check("t4_mid_row",   out_q[20].row, make_row(0, 0, 20));
    end

    // Reset mid-block: 3 rows issued, 2 buffered, 1 in flight.
    do_reset();
    lat = 1; out_ready = 1'b0;
    start(0, 8, 1);
    issue_until(3, 50);
    en[0] = 1'b0;
    check("t5_buffered", RW'(out_valid), RW'(1));
    areset = 1'b1;
    clear_reqs();
    tick();
    areset = 1'b0;
    check("t5_out_valid", RW'(out_valid), '0);
    check("t5_req_ready", RW'(req_ready), '0);
    check("t5_dct_out",   RW'(dct_out_en), '0);
    issue_q.delete();
    out_q.delete();
    start(2, 8, 1);
    repeat (12) tick();
    check("t5_credits_full", RW'(issue_q.size()), RW'(DEP));
    out_ready = 1'b1;
    run_until("t5_outputs", 8, 300);
    for (int i = 0; i < 8; i++) begin
      if (i < out_q.size()) begin
        check("t5_id",   RW'(out_q[i].id), RW'(2));
        check("t5_row",  out_q[i].row, make_row(2, 0, i));
        check("t5_last", RW'(out_q[i].last), RW'(i == 7));
      end
    end
    check("t5_err", RW'(err), '0);

    // Spurious DCT result with no tag pending.
    do_reset();
    lat = 5;
    inj_row = make_row(3, 3, 3);
    inj_en  = 1'b1;
    tick();
    inj_en  = 1'b0;
    check("t6_err_set",   RW'(err), RW'(1));
    check("t6_out_valid", RW'(out_valid), '0);
    repeat (5) tick();
    check("t6_err_sticky",  RW'(err), RW'(1));
    check("t6_out_valid_2", RW'(out_valid), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
